// File: rtl/trap_sequencer_if.sv
// Redirect handshake between the trap sequencer and the fetch unit.
// The sequencer is the master: it presents a target PC and holds it
// until fetch accepts.
interface trap_sequencer_if #(
  parameter int XLEN = 32
) ();
  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_pc;

  modport master (
    output redir_valid,
    output redir_pc,
    input  redir_ready
  );

  modport slave (
    input  redir_valid,
    input  redir_pc,
    output redir_ready
  );
endinterface

// File: rtl/trap_sequencer.sv
// Commit-side trap sequencer: picks the highest-priority exception or
// return request, pulses the matching CSR exception input, drains the
// pipeline for FLUSH_CYCLES cycles, then redirects fetch to the trap
// vector or the return EPC.
module trap_sequencer #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2   // legal range 1..15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_badaddr,
  input  logic            i_ill,
  input  logic            i_inst_misal,
  input  logic            i_ld_misal,
  input  logic            i_st_misal,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_eret,
  input  logic [XLEN-1:0] i_epc,
  input  logic [XLEN-1:0] i_tvec,
  output logic            o_csr_ex_ill,
  output logic            o_csr_ex_inst,
  output logic            o_csr_ex_ld,
  output logic            o_csr_ex_st,
  output logic [XLEN-1:0] o_csr_pc,
  output logic [XLEN-1:0] o_csr_badaddr,
  output logic            o_flush,
  output logic            o_stall,
  trap_sequencer_if.master redir
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REPORT   = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // KIND_NONE is the reset value and also means "no request this cycle".
  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_EXC  = 2'd1,
    KIND_SYS  = 2'd2,
    KIND_RET  = 2'd3
  } kind_t;

  // Exception source one-hot: [3] inst misaligned, [2] illegal,
  // [1] load misaligned, [0] store misaligned.
  localparam logic [3:0] SRC_INST = 4'b1000;
  localparam logic [3:0] SRC_ILL  = 4'b0100;
  localparam logic [3:0] SRC_LD   = 4'b0010;
  localparam logic [3:0] SRC_ST   = 4'b0001;

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  kind_t           kind_q, kind_in;
  logic [3:0]      src_q, src_in;
  logic [XLEN-1:0] pc_q, badaddr_q, target_q;
  logic            take_req;
  logic            load_tvec;

  // Priority decode of the commit-stage request, highest first.
  // NOTE: every signal written here gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    kind_in = KIND_NONE;
    src_in  = 4'b0000;
    if (i_valid) begin
      if (i_inst_misal) begin
        kind_in = KIND_EXC;
        src_in  = SRC_INST;
      end else if (i_ill) begin
        kind_in = KIND_EXC;
        src_in  = SRC_ILL;
      end else if (i_ebreak || i_ecall) begin
        kind_in = KIND_SYS;
      end else if (i_ld_misal) begin
        kind_in = KIND_EXC;
        src_in  = SRC_LD;
      end else if (i_st_misal) begin
        kind_in = KIND_EXC;
        src_in  = SRC_ST;
      end else if (i_eret) begin
        kind_in = KIND_RET;
      end
    end
  end

  // Next-state logic plus the capture strobes for the datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take_req  = 1'b0;
    load_tvec = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (kind_in != KIND_NONE) begin
          take_req = 1'b1;
          cnt_d    = DRAIN_LOAD;
          state_d  = (kind_in == KIND_EXC) ? ST_REPORT : ST_DRAIN;
        end
      end
      ST_REPORT: begin
        cnt_d   = DRAIN_LOAD;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_q == 4'd0) begin
          // The CSR has taken the trap by now, so i_tvec is current.
          load_tvec = (kind_q != KIND_RET);
          state_d   = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_REDIRECT: begin
        if (redir.redir_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and drain counter registers.
  // NOTE: sequential state uses non-blocking assignments so every
  // register samples its inputs from before the edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture in IDLE and trap-vector capture at the end of the drain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      kind_q    <= KIND_NONE;
      src_q     <= 4'b0000;
      pc_q      <= '0;
      badaddr_q <= '0;
      target_q  <= '0;
    end else begin
      if (take_req) begin
        kind_q    <= kind_in;
        src_q     <= src_in;
        pc_q      <= i_pc;
        badaddr_q <= i_badaddr;
        if (kind_in == KIND_RET) target_q <= i_epc;
      end
      if (load_tvec) target_q <= i_tvec;
    end
  end

  // Outputs are either registers or pure decodes of the current state.
  assign o_csr_ex_inst     = (state_q == ST_REPORT) && src_q[3];
  assign o_csr_ex_ill      = (state_q == ST_REPORT) && src_q[2];
  assign o_csr_ex_ld       = (state_q == ST_REPORT) && src_q[1];
  assign o_csr_ex_st       = (state_q == ST_REPORT) && src_q[0];
  assign o_csr_pc          = pc_q;
  assign o_csr_badaddr     = badaddr_q;
  assign o_flush           = (state_q == ST_REPORT) || (state_q == ST_DRAIN);
  assign o_stall           = (state_q != ST_IDLE);
  assign redir.redir_valid = (state_q == ST_REDIRECT);
  assign redir.redir_pc    = target_q;

endmodule
